// File: rtl/run_length_recorder.sv
`default_nettype none
// ============================================================================
// Module      : run_length_recorder
// Description : Rebuilds exact run-of-ones lengths from the saturating 2-bit
//               code of an upstream consecutive-ones counter. Run lengths of
//               at least MIN_LEN go into a small valid/ready FIFO. The module
//               also keeps a saturating run counter and sticky overflow and
//               sequence-error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module run_length_recorder #(
    parameter int LEN_W   = 8,
    parameter int DEPTH   = 4,
    parameter int MIN_LEN = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       result_in,
    input  logic             clr,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [LEN_W-1:0] out_len,
    output logic [15:0]      run_cnt,
    output logic             overflow,
    output logic             seq_err
);

    localparam int               c_AW       = $clog2(DEPTH);
    localparam logic [LEN_W-1:0] c_LEN_MAX  = '1;
    localparam logic [LEN_W-1:0] c_LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] c_LEN_TWO  = LEN_W'(2);
    localparam logic [LEN_W-1:0] c_LEN_TRI  = LEN_W'(3);
    localparam logic [LEN_W-1:0] c_MIN_LEN  = LEN_W'(MIN_LEN);
    localparam logic [c_AW:0]    c_PTR_ONE  = (c_AW+1)'(1);
    localparam logic [15:0]      c_CNT_MAX  = 16'hFFFF;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_mem [0:DEPTH-1];
    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [c_AW:0]    r_wptr;
    logic [c_AW:0]    r_rptr;
    logic [15:0]      r_run_cnt;
    logic             r_overflow;
    logic             r_seq_err;

    logic [0:0]       w_state_nxt;
    logic [LEN_W-1:0] w_len_nxt;
    logic [LEN_W-1:0] w_len_inc;
    logic             w_qualify;
    logic             w_push;
    logic             w_seq_set;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_wr;
    logic             w_drop;

    assign w_len_inc = (r_len == c_LEN_MAX) ? r_len : r_len + c_LEN_ONE;
    assign w_qualify = (r_len >= c_MIN_LEN);

    // Run tracking: decode the upstream code into the next state and length,
    // and decide whether a finished run must be pushed.
    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_push      = 1'b0;
        w_seq_set   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                case (result_in)
                    2'b01: begin
                        w_state_nxt = c_ST_RUN;
                        w_len_nxt   = c_LEN_ONE;
                    end
                    2'b10: begin
                        // Missed the start of the run: resync to its length.
                        w_seq_set   = 1'b1;
                        w_state_nxt = c_ST_RUN;
                        w_len_nxt   = c_LEN_TWO;
                    end
                    2'b11: begin
                        w_seq_set   = 1'b1;
                        w_state_nxt = c_ST_RUN;
                        w_len_nxt   = c_LEN_TRI;
                    end
                    default: begin
                        w_state_nxt = c_ST_IDLE;
                    end
                endcase
            end
            c_ST_RUN: begin
                case (result_in)
                    2'b00: begin
                        w_push      = w_qualify;
                        w_state_nxt = c_ST_IDLE;
                        w_len_nxt   = '0;
                    end
                    2'b01: begin
                        // A new run started without a zero between: close the
                        // old run and restart counting.
                        w_seq_set = 1'b1;
                        w_push    = w_qualify;
                        w_len_nxt = c_LEN_ONE;
                    end
                    default: begin
                        w_len_nxt = w_len_inc;
                        if (r_len == c_LEN_ONE) begin
                            w_seq_set = (result_in != 2'b10);
                        end else begin
                            w_seq_set = (result_in != 2'b11);
                        end
                    end
                endcase
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_len_nxt   = '0;
            end
        endcase
    end

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                     (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign w_pop   = ~w_empty & out_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO succeeds.
    assign w_wr    = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    // Run state and length register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_len   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_len   <= w_len_nxt;
        end
    end

    // FIFO storage. Head reads are masked while empty, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr[c_AW-1:0]] <= r_len;
        end
    end

    // FIFO pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
        end
    end

    // Status counters and sticky flags. A clear overrides any same-cycle update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_cnt  <= '0;
            r_overflow <= 1'b0;
            r_seq_err  <= 1'b0;
        end else if (clr) begin
            r_run_cnt  <= '0;
            r_overflow <= 1'b0;
            r_seq_err  <= 1'b0;
        end else begin
            if (w_push && (r_run_cnt != c_CNT_MAX)) begin
                r_run_cnt <= r_run_cnt + 16'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_seq_set) begin
                r_seq_err <= 1'b1;
            end
        end
    end

    assign out_valid = ~w_empty;
    assign out_len   = w_empty ? '0 : r_mem[r_rptr[c_AW-1:0]];
    assign run_cnt   = r_run_cnt;
    assign overflow  = r_overflow;
    assign seq_err   = r_seq_err;

endmodule
`default_nettype wire

// File: tb/tb_run_length_recorder.sv
`default_nettype none
// ============================================================================
// Module      : tb_run_length_recorder
// Description : Scoreboard bench for run_length_recorder. A reference model
//               counts ones as plain integers and keeps a queue of expected
//               FIFO entries. A negedge monitor compares the DUT outputs
//               against that queue and the expected counter/flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_run_length_recorder;

    localparam int LEN_W   = 8;
    localparam int DEPTH   = 4;
    localparam int MIN_LEN = 3;
    localparam int LEN_MAX = (1 << LEN_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       result_in = 2'b00;
    logic             clr = 1'b0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [LEN_W-1:0] out_len;
    logic [15:0]      run_cnt;
    logic             overflow;
    logic             seq_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int sb_q[$];
    bit mon_en = 1'b0;
    bit m_in_run;
    int m_len;
    int m_cnt;
    bit m_ovf;
    bit m_seq;
    int gen_ones;

    run_length_recorder #(
        .LEN_W  (LEN_W),
        .DEPTH  (DEPTH),
        .MIN_LEN(MIN_LEN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .result_in(result_in),
        .clr      (clr),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_len  (out_len),
        .run_cnt  (run_cnt),
        .overflow (overflow),
        .seq_err  (seq_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_in_run = 1'b0;
        m_len    = 0;
        m_cnt    = 0;
        m_ovf    = 1'b0;
        m_seq    = 1'b0;
        gen_ones = 0;
    endtask

    // One clock edge worth of behaviour, taken from the run-of-ones rules.
    task automatic model_edge(input logic [1:0] c, input logic cl);
        bit push;
        bit sset;
        bit oset;
        int plen;
        push = 1'b0;
        sset = 1'b0;
        oset = 1'b0;
        plen = 0;
        case (c)
            2'b00: begin
                if (m_in_run && m_len >= MIN_LEN) begin
                    push = 1'b1;
                    plen = m_len;
                end
                m_in_run = 1'b0;
                m_len    = 0;
            end
            2'b01: begin
                if (m_in_run) begin
                    sset = 1'b1;
                    if (m_len >= MIN_LEN) begin
                        push = 1'b1;
                        plen = m_len;
                    end
                end
                m_in_run = 1'b1;
                m_len    = 1;
            end
            default: begin
                if (!m_in_run) begin
                    sset     = 1'b1;
                    m_in_run = 1'b1;
                    m_len    = int'(c);
                end else begin
                    if (int'(c) != ((m_len >= 2) ? 3 : 2)) sset = 1'b1;
                    m_len++;
                end
            end
        endcase
        if (push) begin
            if (plen > LEN_MAX) plen = LEN_MAX;
            // The monitor already removed this edge's pop from the queue.
            if (sb_q.size() < DEPTH) sb_q.push_back(plen);
            else oset = 1'b1;
        end
        if (cl) begin
            m_cnt = 0;
            m_ovf = 1'b0;
            m_seq = 1'b0;
        end else begin
            if (push && m_cnt < 65535) m_cnt++;
            if (oset) m_ovf = 1'b1;
            if (sset) m_seq = 1'b1;
        end
    endtask

    task automatic step(input logic [1:0] c, input logic rdy, input logic cl);
        result_in = c;
        out_ready = rdy;
        clr       = cl;
        @(posedge clk);
        model_edge(c, cl);
        #1;
    endtask

    // Legal code stream for n consecutive ones followed by a zero.
    task automatic run_ones(input int n, input logic rdy);
        for (int i = 0; i < n; i++) begin
            step((i == 0) ? 2'b01 : (i == 1) ? 2'b10 : 2'b11, rdy, 1'b0);
        end
        step(2'b00, rdy, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 1'b1, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".out_len"},   32'(out_len),   32'd0);
        chk({tag, ".run_cnt"},   32'(run_cnt),   32'd0);
        chk({tag, ".overflow"},  32'(overflow),  32'd0);
        chk({tag, ".seq_err"},   32'(seq_err),   32'd0);
    endtask

    // Asynchronous reset in the middle of a cycle.
    task automatic mid_reset();
        mon_en = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        model_reset();
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
    endtask

    // Monitor: compare outputs half a cycle after each edge, and retire the
    // head entry when the model says this cycle's handshake completes.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", 32'(out_valid), 32'((sb_q.size() != 0) ? 1 : 0));
            if (sb_q.size() != 0) chk("out_len", 32'(out_len), sb_q[0]);
            else                  chk("out_len_empty", 32'(out_len), 32'd0);
            chk("run_cnt",  32'(run_cnt),  m_cnt);
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("seq_err",  32'(seq_err),  32'(m_seq));
            if (sb_q.size() != 0 && out_ready) void'(sb_q.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] code;
        bit         one;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single run of five ones
        run_ones(5, 1'b0);
        drain(2);

        // Short runs are not recorded, a length-3 run is
        run_ones(1, 1'b0);
        run_ones(2, 1'b0);
        run_ones(3, 1'b0);
        drain(2);

        // Five qualifying runs with the consumer stalled
        for (int k = 0; k < 5; k++) run_ones(3 + k, 1'b0);
        drain(6);

        // Full FIFO while a run ends with a pop in the same cycle
        for (int k = 0; k < 4; k++) run_ones(4 + k, 1'b0);
        step(2'b01, 1'b0, 1'b0);
        step(2'b10, 1'b0, 1'b0);
        step(2'b11, 1'b0, 1'b0);
        step(2'b11, 1'b0, 1'b0);
        step(2'b00, 1'b1, 1'b0);
        drain(6);

        // Illegal sequences then a clear with an entry held in the FIFO
        step(2'b00, 1'b0, 1'b0);
        step(2'b10, 1'b0, 1'b0);
        step(2'b11, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b0);
        drain(3);

        // Long run saturates the length field
        run_ones(300, 1'b0);
        drain(2);

        // Reset in the middle of a run with data in the FIFO
        run_ones(4, 1'b0);
        step(2'b01, 1'b0, 1'b0);
        step(2'b10, 1'b0, 1'b0);
        mid_reset();
        drain(2);

        // Randomised traffic with occasional illegal codes and clears
        gen_ones = 0;
        for (int i = 0; i < 2500; i++) begin
            one = ($urandom_range(0, 99) < 78);
            if (one) code = (gen_ones == 0) ? 2'b01 : (gen_ones == 1) ? 2'b10 : 2'b11;
            else     code = 2'b00;
            gen_ones = one ? gen_ones + 1 : 0;
            if ($urandom_range(0, 99) < 4) code = 2'($urandom_range(0, 3));
            step(code, ($urandom_range(0, 2) != 0), ($urandom_range(0, 59) == 0));
            if (i == 1200) mid_reset();
        end
        drain(8);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
